request_unit: RTL

Sequences the CPU's memory requests between the decoder and the memory interface. It takes per-instruction request flags from the decoder: iREN, dREN, dWEN, halt and atomic. It runs the instruction-fetch / data-access handshake with the memory arbiter, pulses the PC enable once per retired instruction, and latches halt. It also owns the LL/SC link register and its snoop invalidation. The block sits between control_unit and the cache/memory-control port in the single-cycle datapath.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/link_register.sv | 63 ++++++
 rtl/request_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Types shared by the request unit and its link register.
//   reqstate_t : request sequencer states (FETCH, DATA, HALTED)
//   word_t     : one machine word
//   DEFAULT_WORD_LSB : low address bits that select a byte within a word
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int DEFAULT_WORD_LSB = 2;

endpackage

// File: rtl/link_register.sv
// link_register
// Holds the LL/SC reservation: a valid bit and the linked address.
// Ports:
//   clk_i, rst_ni  : clock and asynchronous active-low reset
//   set_i          : LL retiring; load setAddr_i and mark the link valid
//   setAddr_i      : address recorded by an LL
//   clear_i        : SC commit or plain store to the linked word
//   snoop_i        : another agent wrote snoopAddr_i this cycle
//   snoopAddr_i    : snooped write address
//   cmpAddr_i      : address compared against the link
//   match_o        : link valid and cmpAddr_i is in the linked word
module link_register
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_LSB = DEFAULT_WORD_LSB
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] setAddr_i,
  input  logic              clear_i,
  input  logic              snoop_i,
  input  logic [ADDR_W-1:0] snoopAddr_i,
  input  logic [ADDR_W-1:0] cmpAddr_i,
  output logic              match_o
);

  // Byte-select bits are masked out so any address inside the word matches.
  localparam logic [ADDR_W-1:0] WordMask = {ADDR_W{1'b1}} << WORD_LSB;

  logic              linkValid_q, linkValid_d;
  logic [ADDR_W-1:0] linkAddr_q, linkAddr_d;
  logic              snoopHit;

  assign snoopHit = snoop_i & linkValid_q &
                    (((snoopAddr_i ^ linkAddr_q) & WordMask) == '0);
  assign match_o  = linkValid_q &
                    (((cmpAddr_i ^ linkAddr_q) & WordMask) == '0);

  // A new LL wins over a snoop or clear landing in the same cycle.
  always_comb begin
    linkValid_d = linkValid_q;
    linkAddr_d  = linkAddr_q;
    if (set_i) begin
      linkValid_d = 1'b1;
      linkAddr_d  = setAddr_i;
    end else if (clear_i || snoopHit) begin
      linkValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      linkValid_q <= 1'b0;
      linkAddr_q  <= '0;
    end else begin
      linkValid_q <= linkValid_d;
      linkAddr_q  <= linkAddr_d;
    end
  end

endmodule

// File: rtl/request_unit.sv
// request_unit
// Sequences instruction fetch and data access with the memory arbiter,
// strobes the PC once per retired instruction, latches HALT and owns the
// LL/SC link register.
// Ports:
//   CLK, nRST                 : clock and asynchronous active-low reset
//   iREN_in, dREN_in, dWEN_in : decoder fetch / load / store requests
//   halt_in, atomic_in        : decoder HALT and LL/SC flags
//   daddr_in                  : data address from the ALU
//   ihit, dhit                : fetch / data access complete
//   snoop_valid, snoop_addr   : remote write observed on the bus
//   imemREN                   : instruction read enable
//   dmemREN, dmemWEN          : registered data read / write enables
//   pc_en                     : one-cycle PC update strobe
//   sc_success                : SC result, valid while pc_en retires an SC
//   halted                    : sticky halt
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_LSB = DEFAULT_WORD_LSB
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              halt_in,
  input  logic              atomic_in,
  input  logic [ADDR_W-1:0] daddr_in,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              pc_en,
  output logic              sc_success,
  output logic              halted
);

  reqstate_t         state_q, state_d;
  logic              dmemREN_q, dmemREN_d;
  logic              dmemWEN_q, dmemWEN_d;
  logic              atomic_q, atomic_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;

  logic              linkSet, linkClear, linkMatch;
  logic [ADDR_W-1:0] cmpAddr;
  logic              scReq, dataReq;

  // The request is captured at the FETCH exit so decoder changes during
  // DATA have no effect; the captured address drives link updates.
  assign scReq   = atomic_in & dWEN_in;
  assign dataReq = dREN_in | dWEN_in;
  assign cmpAddr = (state_q == DATA) ? reqAddr_q : daddr_in;

  link_register #(
    .ADDR_W   (ADDR_W),
    .WORD_LSB (WORD_LSB)
  ) u_link (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .set_i       (linkSet),
    .setAddr_i   (reqAddr_q),
    .clear_i     (linkClear),
    .snoop_i     (snoop_valid),
    .snoopAddr_i (snoop_addr),
    .cmpAddr_i   (cmpAddr),
    .match_o     (linkMatch)
  );

  // A failed SC never reaches DATA and retires like an ALU op.
  always_comb begin
    state_d   = state_q;
    dmemREN_d = dmemREN_q;
    dmemWEN_d = dmemWEN_q;
    atomic_d  = atomic_q;
    reqAddr_d = reqAddr_q;
    pc_en     = 1'b0;
    linkSet   = 1'b0;
    linkClear = 1'b0;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (halt_in) begin
            state_d = HALTED;
          end else if (dataReq && !(scReq && !linkMatch)) begin
            state_d   = DATA;
            dmemREN_d = dREN_in;
            dmemWEN_d = dWEN_in;
            atomic_d  = atomic_in;
            reqAddr_d = daddr_in;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          state_d   = FETCH;
          dmemREN_d = 1'b0;
          dmemWEN_d = 1'b0;
          atomic_d  = 1'b0;
          pc_en     = 1'b1;
          if (atomic_q && dmemREN_q) begin
            linkSet = 1'b1;
          end else if (dmemWEN_q && (atomic_q || linkMatch)) begin
            linkClear = 1'b1;
          end
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      dmemREN_q <= 1'b0;
      dmemWEN_q <= 1'b0;
      atomic_q  <= 1'b0;
      reqAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      dmemREN_q <= dmemREN_d;
      dmemWEN_q <= dmemWEN_d;
      atomic_q  <= atomic_d;
      reqAddr_q <= reqAddr_d;
    end
  end

  // An SC only holds DATA after passing its link check, so the registered
  // atomic write itself is the success indication.
  assign imemREN    = iREN_in & (state_q == FETCH);
  assign dmemREN    = dmemREN_q;
  assign dmemWEN    = dmemWEN_q;
  assign sc_success = atomic_q & dmemWEN_q;
  assign halted     = (state_q == HALTED);

endmodule
